// File: rtl/rdma_ctyun_sfifo_v2.sv
// Single-clock FIFO for RDMA pipeline staging.
// The RAM read is asynchronous; dout is registered.
// An optional one-word skid register catches the first write that arrives while the FIFO is full.
// Status flags, error pulses, sticky flags and the overflow counter are all registered.
module rdma_ctyun_sfifo_v2 #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 256,
  parameter int unsigned SHOW_AHEAD      = 1,
  parameter int unsigned SKID_EN         = 1,
  parameter int unsigned ALMOST_MTY_VAL  = 2,
  parameter int unsigned ALMOST_FULL_VAL = DEPTH - 2,
  parameter int unsigned ERR_CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_srst,
  input  logic                      i_wr_en,
  input  logic [DATA_WIDTH-1:0]     i_din,
  output logic                      o_full,
  input  logic                      i_rd_en,
  output logic [DATA_WIDTH-1:0]     o_dout,
  output logic                      o_empty,
  output logic                      o_almost_empty,
  output logic                      o_almost_full,
  output logic [$clog2(DEPTH):0]    o_usedw,
  output logic                      o_overflow,
  output logic                      o_underflow,
  output logic                      o_ovf_sticky,
  output logic                      o_udf_sticky,
  output logic [ERR_CNT_W-1:0]      o_ovf_cnt,
  input  logic                      i_clr_err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_usedw;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_full, r_empty, r_almost_empty, r_almost_full;
  logic                  r_ovf, r_udf, r_ovf_sticky, r_udf_sticky;
  logic [ERR_CNT_W-1:0]  r_ovf_cnt;

  logic                  w_wr_acc, w_rd_acc, w_skid_cap, w_skid_drain;
  logic                  w_ram_we, w_ovf, w_udf;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [ADDR_W-1:0]     w_wptr_nxt, w_rptr_nxt;
  logic [CNT_W-1:0]      w_usedw_nxt, w_cnt_after_rd;
  logic                  w_skid_valid_nxt;
  logic [DATA_WIDTH-1:0] w_skid_data_nxt, w_dout_nxt;
  logic                  w_ovf_sticky_nxt, w_udf_sticky_nxt;
  logic [ERR_CNT_W-1:0]  w_ovf_cnt_nxt;

  // Next-state logic: acceptance, skid handling, pointer/count and error bookkeeping
  always_comb begin
    w_wr_acc         = 1'b0;
    w_rd_acc         = 1'b0;
    w_skid_cap       = 1'b0;
    w_skid_drain     = 1'b0;
    w_ovf            = 1'b0;
    w_udf            = 1'b0;
    w_ram_we         = 1'b0;
    w_ram_wdata      = i_din;
    w_wptr_nxt       = r_wptr;
    w_rptr_nxt       = r_rptr;
    w_usedw_nxt      = r_usedw;
    w_cnt_after_rd   = r_usedw;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    w_dout_nxt       = r_dout;
    w_ovf_sticky_nxt = r_ovf_sticky;
    w_udf_sticky_nxt = r_udf_sticky;
    w_ovf_cnt_nxt    = r_ovf_cnt;

    if (i_srst) begin
      // Flush everything except the error history
      w_wptr_nxt       = '0;
      w_rptr_nxt       = '0;
      w_usedw_nxt      = '0;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = '0;
      w_dout_nxt       = '0;
    end else begin
      w_wr_acc     = i_wr_en & ~r_full;
      w_rd_acc     = i_rd_en & ~r_empty;
      w_udf        = i_rd_en & r_empty;
      w_skid_cap   = (SKID_EN != 0) & i_wr_en & r_full & ~r_skid_valid;
      w_skid_drain = (SKID_EN != 0) & r_skid_valid & (r_usedw != CNT_W'(DEPTH));
      w_ovf        = i_wr_en & r_full & ((SKID_EN == 0) | r_skid_valid);

      // Skid replay and external write never coincide: skid_valid forces full
      w_ram_we    = w_wr_acc | w_skid_drain;
      w_ram_wdata = r_skid_valid ? r_skid_data : i_din;

      w_wptr_nxt     = r_wptr + ADDR_W'(w_ram_we);
      w_rptr_nxt     = r_rptr + ADDR_W'(w_rd_acc);
      w_cnt_after_rd = r_usedw - CNT_W'(w_rd_acc);
      w_usedw_nxt    = w_cnt_after_rd + CNT_W'(w_ram_we);

      if (w_skid_cap) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_data_nxt  = i_din;
      end else if (w_skid_drain) begin
        w_skid_valid_nxt = 1'b0;
      end

      if (SHOW_AHEAD != 0) begin
        // Present the new head; bypass the RAM when the write lands in an otherwise empty FIFO
        if (w_cnt_after_rd != '0) begin
          w_dout_nxt = r_mem[w_rptr_nxt];
        end else if (w_ram_we) begin
          w_dout_nxt = w_ram_wdata;
        end
      end else if (w_rd_acc) begin
        w_dout_nxt = r_mem[r_rptr];
      end

      // A new error in the same cycle as clr_err takes precedence over the clear
      if (w_ovf) begin
        w_ovf_sticky_nxt = 1'b1;
        if (i_clr_err) begin
          w_ovf_cnt_nxt = ERR_CNT_W'(1);
        end else if (~&r_ovf_cnt) begin
          w_ovf_cnt_nxt = r_ovf_cnt + ERR_CNT_W'(1);
        end
      end else if (i_clr_err) begin
        w_ovf_sticky_nxt = 1'b0;
        w_ovf_cnt_nxt    = '0;
      end

      if (w_udf) begin
        w_udf_sticky_nxt = 1'b1;
      end else if (i_clr_err) begin
        w_udf_sticky_nxt = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_usedw        <= '0;
      r_skid_valid   <= 1'b0;
      r_skid_data    <= '0;
      r_dout         <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_ovf          <= 1'b0;
      r_udf          <= 1'b0;
      r_ovf_sticky   <= 1'b0;
      r_udf_sticky   <= 1'b0;
      r_ovf_cnt      <= '0;
    end else begin
      r_wptr         <= w_wptr_nxt;
      r_rptr         <= w_rptr_nxt;
      r_usedw        <= w_usedw_nxt;
      r_skid_valid   <= w_skid_valid_nxt;
      r_skid_data    <= w_skid_data_nxt;
      r_dout         <= w_dout_nxt;
      r_full         <= (w_usedw_nxt == CNT_W'(DEPTH)) | w_skid_valid_nxt;
      r_empty        <= (w_usedw_nxt == '0);
      r_almost_empty <= (w_usedw_nxt < CNT_W'(ALMOST_MTY_VAL));
      r_almost_full  <= (w_usedw_nxt >= CNT_W'(ALMOST_FULL_VAL));
      r_ovf          <= w_ovf;
      r_udf          <= w_udf;
      r_ovf_sticky   <= w_ovf_sticky_nxt;
      r_udf_sticky   <= w_udf_sticky_nxt;
      r_ovf_cnt      <= w_ovf_cnt_nxt;
    end
  end

  // Storage array, no reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_wptr] <= w_ram_wdata;
    end
  end

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;
  assign o_almost_full  = r_almost_full;
  assign o_usedw        = r_usedw;
  assign o_dout         = r_dout;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;
  assign o_ovf_sticky   = r_ovf_sticky;
  assign o_udf_sticky   = r_udf_sticky;
  assign o_ovf_cnt      = r_ovf_cnt;

endmodule

// File: tb/tb_rdma_ctyun_sfifo_v2.sv
// Testbench for rdma_ctyun_sfifo_v2.
// u_dut: show-ahead FIFO with skid, checked through a scoreboard queue of expected pops.
// u_sa0: registered-read FIFO without skid, checked with directed compares.
module tb_rdma_ctyun_sfifo_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, srst, wr_en, rd_en, clr_err;
  logic [31:0] din;
  logic        full, empty, almost_empty, almost_full, overflow, underflow, ovf_sticky, udf_sticky;
  logic [31:0] dout;
  logic [4:0]  usedw;
  logic [3:0]  ovf_cnt;

  logic        b_srst, b_wr, b_rd, b_clr;
  logic [31:0] b_din;
  logic        b_full, b_empty, b_ae, b_af, b_ovf, b_udf, b_ovfs, b_udfs;
  logic [31:0] b_dout;
  logic [2:0]  b_usedw;
  logic [3:0]  b_ovf_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  rdma_ctyun_sfifo_v2 #(.DATA_WIDTH(32), .DEPTH(16), .SHOW_AHEAD(1), .SKID_EN(1), .ERR_CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_srst(srst), .i_wr_en(wr_en), .i_din(din), .o_full(full),
    .i_rd_en(rd_en), .o_dout(dout), .o_empty(empty), .o_almost_empty(almost_empty),
    .o_almost_full(almost_full), .o_usedw(usedw), .o_overflow(overflow), .o_underflow(underflow),
    .o_ovf_sticky(ovf_sticky), .o_udf_sticky(udf_sticky), .o_ovf_cnt(ovf_cnt), .i_clr_err(clr_err)
  );

  rdma_ctyun_sfifo_v2 #(.DATA_WIDTH(32), .DEPTH(4), .SHOW_AHEAD(0), .SKID_EN(0), .ERR_CNT_W(4)) u_sa0 (
    .clk(clk), .rst_n(rst_n), .i_srst(b_srst), .i_wr_en(b_wr), .i_din(b_din), .o_full(b_full),
    .i_rd_en(b_rd), .o_dout(b_dout), .o_empty(b_empty), .o_almost_empty(b_ae),
    .o_almost_full(b_af), .o_usedw(b_usedw), .o_overflow(b_ovf), .o_underflow(b_udf),
    .o_ovf_sticky(b_ovfs), .o_udf_sticky(b_udfs), .o_ovf_cnt(b_ovf_cnt), .i_clr_err(b_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      din   = base + 32'(i);
      if (push) exp_q.push_back(din);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) step();
    rd_en = 1'b0;
  endtask

  // Monitor: every accepted read pops the scoreboard and compares the presented head word
  always @(negedge clk) begin
    if (rst_n && !srst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no readable word at %0t", dout, $time);
      end else begin
        chk("pop_data", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    b_srst = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;
    repeat (2) step();

    // Reset values
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_usedw", 32'(usedw), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_pulses", {30'd0, overflow, underflow}, 32'd0);
    chk("rst_sticky", {30'd0, ovf_sticky, udf_sticky}, 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Show-ahead latency: word visible one cycle after the write
    wr_en = 1'b1; din = 32'hA5; exp_q.push_back(32'hA5);
    step();
    wr_en = 1'b0;
    chk("sa_empty", 32'(empty), 32'd0);
    chk("sa_dout", dout, 32'hA5);
    drain(1);
    chk("sa_empty_after", 32'(empty), 32'd1);
    chk("sa_dout_hold", dout, 32'hA5);

    // Fill 0..15 with per-word status, then drain in order
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 32'(i); exp_q.push_back(32'(i));
      step();
      chk("fill_usedw", 32'(usedw), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_aempty", 32'(almost_empty), 32'((i + 1) < 2));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    wr_en = 1'b0;
    drain(16);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_usedw", 32'(usedw), 32'd0);

    // Simultaneous read+write on empty
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h33; exp_q.push_back(32'h33);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_mt_udf", 32'(underflow), 32'd1);
    chk("rdwr_mt_usedw", 32'(usedw), 32'd1);
    chk("rdwr_mt_udfs", 32'(udf_sticky), 32'd1);
    step();
    chk("udf_pulse_end", 32'(underflow), 32'd0);
    drain(1);

    // Skid: capture, overflow on second, replay after a read
    fill(32'h100, 16, 1'b1);
    wr_en = 1'b1; din = 32'h11; exp_q.push_back(32'h11);
    step();
    chk("skid_no_ovf", 32'(overflow), 32'd0);
    chk("skid_full", 32'(full), 32'd1);
    din = 32'h22;
    step();
    wr_en = 1'b0;
    chk("skid_ovf", 32'(overflow), 32'd1);
    chk("skid_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("skid_ovfs", 32'(ovf_sticky), 32'd1);
    step();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    drain(1);
    chk("skid_rd_usedw", 32'(usedw), 32'd15);
    step();
    chk("skid_drain_usedw", 32'(usedw), 32'd16);
    chk("skid_drain_full", 32'(full), 32'd1);
    drain(17);
    chk("skid_all_empty", 32'(empty), 32'd1);

    // Simultaneous read+write on full: read pops, write goes to the skid
    fill(32'h200, 16, 1'b1);
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h44; exp_q.push_back(32'h44);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_full_ovf", 32'(overflow), 32'd0);
    step();
    chk("rdwr_full_usedw", 32'(usedw), 32'd16);
    drain(17);

    // Half fill, 1000 cycles of streaming across pointer wrap
    fill(32'h1000, 8, 1'b1);
    for (int k = 0; k < 1000; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 32'h2000 + 32'(k); exp_q.push_back(din);
      step();
      chk("stream_usedw", 32'(usedw), 32'd8);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    drain(8);
    chk("stream_empty", 32'(empty), 32'd1);

    // Synchronous flush keeps error history
    fill(32'h300, 5, 1'b0);
    srst = 1'b1; wr_en = 1'b1; din = 32'h3FF;
    step();
    srst = 1'b0; wr_en = 1'b0;
    chk("srst_usedw", 32'(usedw), 32'd0);
    chk("srst_empty", 32'(empty), 32'd1);
    chk("srst_full", 32'(full), 32'd0);
    chk("srst_dout", dout, 32'd0);
    chk("srst_sticky", {30'd0, ovf_sticky, udf_sticky}, 32'd3);
    chk("srst_ovf_cnt", 32'(ovf_cnt), 32'd1);
    fill(32'h55, 1, 1'b1);
    drain(1);

    // Error clear, saturation, clear coincident with overflow
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_sticky", {30'd0, ovf_sticky, udf_sticky}, 32'd0);
    chk("clr_cnt", 32'(ovf_cnt), 32'd0);
    fill(32'h400, 16, 1'b1);
    wr_en = 1'b1; din = 32'h4FF; exp_q.push_back(32'h4FF);
    step();
    chk("sat_skid_no_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k <= 19; k++) begin
      din = 32'h500 + 32'(k);
      step();
      if (k == 5) chk("sat_cnt5", 32'(ovf_cnt), 32'd5);
    end
    chk("sat_cnt", 32'(ovf_cnt), 32'hF);
    clr_err = 1'b1;
    step();
    wr_en = 1'b0; clr_err = 1'b0;
    chk("clr_coinc_sticky", 32'(ovf_sticky), 32'd1);
    chk("clr_coinc_cnt", 32'(ovf_cnt), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr2_cnt", 32'(ovf_cnt), 32'd0);
    drain(17);
    chk("sat_drain_empty", 32'(empty), 32'd1);

    // Registered-read instance without skid
    b_wr = 1'b1; b_din = 32'hA5;
    step();
    b_wr = 1'b0;
    chk("b_empty", 32'(b_empty), 32'd0);
    chk("b_usedw", 32'(b_usedw), 32'd1);
    chk("b_dout_not_loaded", b_dout, 32'd0);
    b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    chk("b_dout_loaded", b_dout, 32'hA5);
    chk("b_empty_after", 32'(b_empty), 32'd1);
    step();
    chk("b_dout_hold", b_dout, 32'hA5);
    for (int i = 0; i < 5; i++) begin
      b_wr = 1'b1; b_din = 32'h61 + 32'(i);
      step();
    end
    b_wr = 1'b0;
    chk("b_ovf", 32'(b_ovf), 32'd1);
    chk("b_ovf_cnt", 32'(b_ovf_cnt), 32'd1);
    chk("b_full", 32'(b_full), 32'd1);
    chk("b_usedw_full", 32'(b_usedw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      b_rd = 1'b1;
      step();
      chk("b_rd_data", b_dout, 32'h61 + 32'(i));
    end
    b_rd = 1'b0;
    chk("b_drain_empty", 32'(b_empty), 32'd1);

    // Asynchronous reset in the middle of a burst
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pre_rst_udfs", 32'(udf_sticky), 32'd1);
    wr_en = 1'b1; din = 32'h700;
    step();
    din = 32'h701;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_usedw", 32'(usedw), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout", dout, 32'd0);
    chk("arst_sticky", {30'd0, ovf_sticky, udf_sticky}, 32'd0);
    chk("arst_flags", {28'd0, full, almost_full, almost_empty, underflow}, 32'd2);
    wr_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
